// File: rtl/ifu_align_expand.sv
// Fetch-word to instruction aligner: a halfword FIFO that re-packs fetch words into
// 16/32-bit instructions. Define IFU_RVC_EN to enable the RVC-to-RV32I expander.
module ifu_align_expand #(
   parameter int          FW       = 32,
   parameter int          BUF_HW   = 8,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic [31:0]   flush_pc,
   input  logic          fetch_valid,
   output logic          fetch_ready,
   input  logic [FW-1:0] fetch_data,
   input  logic          fetch_err,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_instr,
   output logic [31:0]   out_pc,
   output logic          out_is16,
   output logic          out_illegal,
   output logic          out_err
);

   localparam int HPW  = FW / 16;
   localparam int PW   = $clog2(BUF_HW);
   localparam int CW   = PW + 1;
   localparam int OFFW = $clog2(FW / 8);

   typedef logic [PW-1:0] ptr_t;

   logic [15:0]     memData [BUF_HW];
   logic            memErr  [BUF_HW];

   ptr_t            rdPtr_q, rdPtr_d;
   ptr_t            wrPtr_q, wrPtr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     pc_q, pc_d;
   logic            drop_q, drop_d;

   logic            push, pop;
   logic [OFFW-2:0] dropN;
   logic [CW-1:0]   pushN, popN;
   ptr_t            rdPtr1;
   logic [15:0]     hw0, hw1;
   logic            err0, err1;
   logic [1:0]      need;
   logic [31:0]     instr;
   logic            is16, illegal, errAll;

`ifdef IFU_RVC_EN
   // Returns {illegal, expanded RV32I instruction} for one compressed parcel.
   function automatic logic [32:0] expandRvc(input logic [15:0] c);
      logic [31:0] i;
      logic        ill;
      logic [4:0]  rd, rs2, rdp, rs1p;
      i    = '0;
      ill  = 1'b0;
      rd   = c[11:7];
      rs2  = c[6:2];
      rdp  = {2'b01, c[4:2]};
      rs1p = {2'b01, c[9:7]};
      case ({c[15:13], c[1:0]})
         5'b000_00: begin
            ill = (c[12:5] == 8'h00);
            i   = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, 7'h13};
         end
         5'b010_00: i = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, 7'h03};
         5'b110_00: i = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'h23};
         5'b000_01: i = {{6{c[12]}}, c[12], c[6:2], rd, 3'b000, rd, 7'h13};
         5'b001_01: i = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12],
                         {8{c[12]}}, 5'd1, 7'h6f};
         5'b010_01: i = {{6{c[12]}}, c[12], c[6:2], 5'd0, 3'b000, rd, 7'h13};
         5'b011_01: begin
            ill = ({c[12], c[6:2]} == 6'd0);
            if (rd == 5'd2) begin
               i = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'h13};
            end else begin
               i = {{14{c[12]}}, c[12], c[6:2], rd, 7'h37};
            end
         end
         5'b100_01: begin
            case (c[11:10])
               2'b00: begin
                  ill = c[12];
                  i   = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
               end
               2'b01: begin
                  ill = c[12];
                  i   = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
               end
               2'b10: i = {{6{c[12]}}, c[12], c[6:2], rs1p, 3'b111, rs1p, 7'h13};
               default: begin
                  // c[12]=1 selects the RV64-only SUBW/ADDW group
                  ill = c[12];
                  case (c[6:5])
                     2'b00:   i = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'h33};
                     2'b01:   i = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'h33};
                     2'b10:   i = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'h33};
                     default: i = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'h33};
                  endcase
               end
            endcase
         end
         5'b101_01: i = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12],
                         {8{c[12]}}, 5'd0, 7'h6f};
         5'b110_01: i = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 3'b000,
                         c[11:10], c[4:3], c[12], 7'h63};
         5'b111_01: i = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 3'b001,
                         c[11:10], c[4:3], c[12], 7'h63};
         5'b000_10: begin
            ill = c[12];
            i   = {7'b0, c[6:2], rd, 3'b001, rd, 7'h13};
         end
         5'b010_10: begin
            ill = (rd == 5'd0);
            i   = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'h03};
         end
         5'b100_10: begin
            if (!c[12]) begin
               if (rs2 == 5'd0) begin
                  ill = (rd == 5'd0);
                  i   = {12'b0, rd, 3'b000, 5'd0, 7'h67};
               end else begin
                  i = {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
               end
            end else if (rs2 == 5'd0) begin
               if (rd == 5'd0) begin
                  i = 32'h0010_0073;
               end else begin
                  i = {12'b0, rd, 3'b000, 5'd1, 7'h67};
               end
            end else begin
               i = {7'b0, rs2, rd, 3'b000, rd, 7'h33};
            end
         end
         5'b110_10: i = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'h23};
         default:   ill = 1'b1;
      endcase
      return {ill, i};
   endfunction
`endif

   assign fetch_ready = !flush && ((CW'(BUF_HW) - count_q) >= CW'(HPW));
   assign push        = fetch_valid && fetch_ready;

   // After a flush the FIFO is empty, so pc_q still holds the flush target and its
   // low bits say how many leading halfwords of the first word to skip.
   assign dropN = drop_q ? pc_q[OFFW-1:1] : '0;
   assign pushN = CW'(HPW) - CW'(dropN);

   always_ff @(posedge clk) begin
      if (push) begin
         for (int i = 0; i < HPW; i++) begin
            if (i >= int'(dropN)) begin
               memData[wrPtr_q + ptr_t'(i) - ptr_t'(dropN)] <= fetch_data[16*i +: 16];
               memErr[wrPtr_q + ptr_t'(i) - ptr_t'(dropN)]  <= fetch_err;
            end
         end
      end
   end

   assign rdPtr1 = rdPtr_q + ptr_t'(1);
   assign hw0    = memData[rdPtr_q];
   assign hw1    = memData[rdPtr1];
   assign err0   = memErr[rdPtr_q];
   assign err1   = memErr[rdPtr1];

   always_comb begin
      need    = 2'd2;
      instr   = {hw1, hw0};
      is16    = 1'b0;
      illegal = 1'b0;
      errAll  = err0 | err1;
`ifdef IFU_RVC_EN
      if (hw0[1:0] != 2'b11) begin
         logic [32:0] exp;
         exp     = expandRvc(hw0);
         need    = 2'd1;
         is16    = 1'b1;
         errAll  = err0;
         illegal = exp[32];
         instr   = exp[32] ? {16'h0000, hw0} : exp[31:0];
      end
`else
      illegal = (hw0[1:0] != 2'b11);
`endif
   end

   assign out_valid   = (count_q >= CW'(need));
   assign out_instr   = instr;
   assign out_pc      = pc_q;
   assign out_is16    = is16;
   assign out_illegal = illegal;
   assign out_err     = errAll;

   assign pop  = out_valid && out_ready && !flush;
   assign popN = pop ? CW'(need) : '0;

   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      if (flush) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
         count_d = '0;
         pc_d    = flush_pc;
         drop_d  = 1'b1;
      end else begin
         if (push) begin
            wrPtr_d = wrPtr_q + ptr_t'(pushN);
            drop_d  = 1'b0;
         end
         if (pop) begin
            rdPtr_d = rdPtr_q + ptr_t'(need);
            pc_d    = pc_q + {29'b0, need, 1'b0};
         end
         count_d = count_q + (push ? pushN : '0) - popN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
         pc_q    <= RESET_PC;
         drop_q  <= 1'b0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
      end
   end

endmodule

// File: doc/ifu_align_expand.md
IFU_ALIGN_EXPAND -- requirements
Module: ifu_align_expand

Interface
- REQ-001: Parameter FW, default 32, SHALL set the fetch word width in bits; legal values are 32 and 64.
- REQ-002: Parameter BUF_HW, default 8, SHALL set the halfword buffer depth; it is a power of 2 and at least 2*FW/16.
- REQ-003: Parameter RESET_PC, default 32'h0, SHALL set the PC loaded at reset.
- REQ-004: clk  in  1  SHALL be the single clock; all state updates on rising edge.
- REQ-005: rst_n  in  1  SHALL be the asynchronous, active-low reset.
- REQ-006: flush  in  1 and flush_pc  in  32 SHALL restart the stream at flush_pc.
- REQ-007: fetch_valid in 1, fetch_ready out 1, fetch_data in FW, fetch_err in 1 SHALL form the fetch-word input handshake.
- REQ-008: out_valid out 1, out_ready in 1, out_instr out 32, out_pc out 32, out_is16 out 1, out_illegal out 1, out_err out 1 SHALL form the instruction output handshake.

Function
- REQ-009: The block SHALL hold a circular halfword FIFO (BUF_HW entries, each 16 data bits plus 1 err bit) with read/write pointers wrapping modulo BUF_HW and a count of width log2(BUF_HW)+1.
- REQ-010: fetch_ready SHALL be 1 when (BUF_HW - count) >= FW/16 and flush is 0.
- REQ-011: On fetch_valid&fetch_ready, all FW/16 halfwords SHALL be written in ascending address order, each tagged with fetch_err, except on the first beat after flush.
- REQ-012: On that first beat, the lowest flush_pc[log2(FW/8)-1:1] halfwords SHALL be dropped.
- REQ-013: Head halfword hw0[1:0]!=2'b11 SHALL mark a 16-bit instruction requiring count>=1; otherwise it SHALL mark a 32-bit instruction requiring count>=2 (hw1 = next entry).
- REQ-014: out_valid SHALL be 1 when the required count is present; outputs are combinational from FIFO head, so a word accepted at edge N presents at most one instruction from cycle N+1.
- REQ-015: On out_valid&out_ready, 1 or 2 halfwords SHALL be popped and out_pc SHALL advance by 2 or 4 (modulo 2^32).
- REQ-016: A 32-bit instruction straddling fetch words SHALL hold out_valid=0 until its upper halfword is written.
- REQ-017: A 16-bit instruction SHALL be expanded to its RV32I equivalent per the RVC v2.2 RV32 tables (quadrants 0-2, integer only), with out_is16=1.
- REQ-018: Reserved, HINT-less illegal, FP and 16'h0000 encodings SHALL drive out_illegal=1, out_instr={16'h0,hw0}, and still pop one halfword.
- REQ-019: out_err SHALL be the OR of err bits of all halfwords forming the instruction.
- REQ-020: Simultaneous push and pop SHALL update count by the net amount in one cycle.
- REQ-021: Flush SHALL have priority: in that cycle no push or pop takes effect, pointers and count clear, out_pc loads flush_pc, and the drop-first-beat flag sets.

Reset
- REQ-022: While rst_n=0, pointers=0, count=0, out_pc=RESET_PC, and the drop flag=0 SHALL hold, giving out_valid=0 and fetch_ready=1.
- REQ-023: Reset asserted mid-transfer SHALL discard buffered halfwords immediately, without waiting for a clock edge.

Configuration
- REQ-024: With IFU_RVC_EN defined, REQ-013..REQ-018 SHALL apply in full.
- REQ-025: Without IFU_RVC_EN, the expander SHALL be absent and every instruction SHALL consume 2 halfwords; out_is16 is tied 0 and out_illegal=1 when hw0[1:0]!=2'b11, with out_instr={hw1,hw0}.

Verification
- REQ-026: FW=32, RESET_PC=0, push 32'h4501_0001, out_ready=1 -> out 32'h00000013 pc 0 is16=1, then 32'h00000513 pc 2.
- REQ-027: Push 32'h0513_0001 then 32'h0000_0000 one cycle later -> nop@0, then 32'h00000513 pc 2 is16=0 only after second word, then illegal 32'h0 pc 6.
- REQ-028: flush=1 flush_pc=32'h102, then push 32'h8082_FFFF -> low halfword dropped; out 32'h00008067 pc 32'h102.
- REQ-029: BUF_HW=8, out_ready=0, push 4 words -> fetch_ready=0 after 4th accept; 5th word held; one out_ready pop of a 32-bit instr -> fetch_ready=1 next cycle.
- REQ-030: Push with fetch_err=1 for a word holding a straddling 32-bit upper half -> that instruction has out_err=1; prior instruction out_err=0.
- REQ-031: Assert rst_n=0 with 3 halfwords buffered -> out_valid=0 and fetch_ready=1 immediately, out_pc=RESET_PC.
